rc4_stream_ctrl: RTL and testbench

- Sequencer and arbiter in front of one rc4 PRGA core.
- Holds a host-written key, restarts the core on command and serially feeds the key bytes during the core's key-read window.
- Captures every fresh keystream byte into a small FIFO and shares the stream among NREQ requesters with round-robin grants.
- The core cannot be stalled, so bytes arriving at a full FIFO are dropped and flagged.

---
 rtl/rc4_stream_ctrl_pkg.sv | 25 ++
 rtl/rc4_ks_fifo.sv | 67 ++++++
 rtl/rc4_stream_ctrl.sv | 158 +++++++++++++++
 tb/tb_rc4_stream_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_stream_ctrl_pkg.sv
// Shared constants and state encoding for the rc4 keystream sequencer.
// KEY_SIZE must match the PRGA core's key length.
package rc4_stream_ctrl_pkg;

  localparam int KEY_SIZE = 16;
  localparam int BYTE_W   = 8;

  typedef enum logic [2:0] {
    CS_IDLE     = 3'd0,
    CS_CORE_RST = 3'd1,
    CS_KEYFEED  = 3'd2,
    CS_WARMUP   = 3'd3,
    CS_RUN      = 3'd4
  } ctrl_state_e;

  function automatic logic state_is_busy(input ctrl_state_e s);
    return (s == CS_CORE_RST) || (s == CS_KEYFEED) || (s == CS_WARMUP);
  endfunction

  // Core bytes are only meaningful once the key feed has completed.
  function automatic logic capture_enabled(input ctrl_state_e s);
    return (s == CS_WARMUP) || (s == CS_RUN);
  endfunction

endpackage

// File: rtl/rc4_ks_fifo.sv
// Small keystream buffer: power-of-two depth, head visible combinationally,
// asynchronous clear plus a synchronous flush used on every restart.
module rc4_ks_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

  // A push into a full buffer is still legal when the head leaves this cycle.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/rc4_stream_ctrl.sv
// Sequencer/arbiter in front of one rc4 PRGA core: rekeys the core, buffers
// its keystream and hands bytes to NREQ consumers round-robin.
module rc4_stream_ctrl #(
  parameter int KEY_SIZE   = rc4_stream_ctrl_pkg::KEY_SIZE,
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int KAW       = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1,
  localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            key_wr_en_i,
  input  logic [KAW-1:0]  key_addr_i,
  input  logic [7:0]      key_data_i,
  output logic            busy_o,
  output logic            overrun_o,
  output logic            core_rst_o,
  output logic [7:0]      core_key_o,
  input  logic            core_ready_i,
  input  logic [7:0]      core_k_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [7:0]      out_byte_o
);

  import rc4_stream_ctrl_pkg::*;

  ctrl_state_e    state_q;
  ctrl_state_e    state_d;
  logic [KAW-1:0] kidx_q;
  logic [KAW-1:0] kidx_d;
  logic           core_rst_q;
  logic           core_rst_d;
  logic [7:0]     core_key_q;
  logic [7:0]     core_key_d;
  logic           overrun_q;
  logic           overrun_d;
  logic [PW-1:0]  rr_q;
  logic [PW-1:0]  gidx;
  logic           gfound;
  logic [7:0]     key_buf_q [KEY_SIZE];

  logic           key_we;
  logic           capture;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  unused_fifo_count;
  logic [7:0]     fifo_head;

  // Sequencer next state; start wins everywhere except inside CORE_RST.
  always_comb begin
    state_d = state_q;
    kidx_d  = kidx_q;
    if (start_i && state_q != CS_CORE_RST) begin
      state_d = CS_CORE_RST;
    end else begin
      case (state_q)
        CS_CORE_RST: begin
          state_d = CS_KEYFEED;
          kidx_d  = '0;
        end
        CS_KEYFEED: begin
          if (kidx_q == KAW'(KEY_SIZE - 1)) state_d = CS_WARMUP;
          else                               kidx_d  = kidx_q + 1'b1;
        end
        CS_WARMUP: begin
          if (core_ready_i) state_d = CS_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Core-facing outputs are registered, so they are derived from the next state.
  assign core_rst_d = (state_d == CS_IDLE) || (state_d == CS_CORE_RST);
  assign core_key_d = (state_d == CS_KEYFEED) ? key_buf_q[kidx_d] : 8'h00;

  assign key_we  = key_wr_en_i
                && (state_q == CS_IDLE || state_q == CS_WARMUP || state_q == CS_RUN)
                && (32'(key_addr_i) < 32'(KEY_SIZE));
  assign capture = core_ready_i && capture_enabled(state_q);

  always_comb begin
    overrun_d = overrun_q;
    if (state_q == CS_CORE_RST)              overrun_d = 1'b0;
    else if (capture && fifo_full && !pop)   overrun_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CS_IDLE;
      kidx_q     <= '0;
      core_rst_q <= 1'b1;
      core_key_q <= 8'h00;
      overrun_q  <= 1'b0;
      rr_q       <= PW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      kidx_q     <= kidx_d;
      core_rst_q <= core_rst_d;
      core_key_q <= core_key_d;
      overrun_q  <= overrun_d;
      if (gfound) rr_q <= gidx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < KEY_SIZE; i++) key_buf_q[i] <= 8'h00;
    end else if (key_we) begin
      key_buf_q[key_addr_i] <= key_data_i;
    end
  end

  // Round-robin: first requester after the last one served.
  always_comb begin
    gfound = 1'b0;
    gidx   = '0;
    gnt_o  = '0;
    if (state_q == CS_RUN && !fifo_empty) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!gfound && req_i[(int'(rr_q) + k) % NREQ]) begin
          gfound = 1'b1;
          gidx   = PW'((int'(rr_q) + k) % NREQ);
        end
      end
    end
    if (gfound) gnt_o[gidx] = 1'b1;
  end

  assign pop = gfound;

  rc4_ks_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (state_q == CS_CORE_RST),
    .push_i  (capture),
    .pop_i   (pop),
    .din_i   (core_k_i),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  assign busy_o     = state_is_busy(state_q);
  assign overrun_o  = overrun_q;
  assign core_rst_o = core_rst_q;
  assign core_key_o = core_key_q;
  assign out_byte_o = fifo_head;

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Directed bench for rc4_stream_ctrl with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_rc4_stream_ctrl;

  localparam int KS = 3;
  localparam int NR = 2;
  localparam int FD = 4;
  localparam int P_IDLE = 0, P_RST = 1, P_FEED = 2, P_WARM = 3, P_RUN = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          key_wr_en;
  logic [1:0]    key_addr;
  logic [7:0]    key_data;
  logic          busy;
  logic          overrun;
  logic          core_rst;
  logic [7:0]    core_key;
  logic          core_ready;
  logic [7:0]    core_k;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [7:0]    out_byte;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rc4_stream_ctrl #(
    .KEY_SIZE   (KS),
    .NREQ       (NR),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .key_wr_en_i  (key_wr_en),
    .key_addr_i   (key_addr),
    .key_data_i   (key_data),
    .busy_o       (busy),
    .overrun_o    (overrun),
    .core_rst_o   (core_rst),
    .core_key_o   (core_key),
    .core_ready_i (core_ready),
    .core_k_i     (core_k),
    .req_i        (req),
    .gnt_o        (gnt),
    .out_byte_o   (out_byte)
  );

  // Reference model: phase, feed index, a byte queue, served-last pointer.
  int         m_phase = P_IDLE;
  int         m_idx = 0;
  logic [7:0] m_q[$];
  logic       m_ovr = 1'b0;
  int         m_ptr = NR - 1;
  logic [7:0] m_key[KS];
  int         m_g;
  logic [7:0] recv0[$];
  logic [7:0] recv1[$];

  function automatic int pick();
    if (m_phase != P_RUN || m_q.size() == 0) return -1;
    for (int k = 1; k <= NR; k++) begin
      if (req[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_idx   = 0;
      m_q.delete();
      m_ovr   = 1'b0;
      m_ptr   = NR - 1;
      for (int i = 0; i < KS; i++) m_key[i] = 8'h00;
    end else begin
      m_g = pick();
      if (m_g >= 0) begin
        void'(m_q.pop_front());
        m_ptr = m_g;
      end
      if (core_ready && (m_phase == P_WARM || m_phase == P_RUN)) begin
        if (m_q.size() < FD) m_q.push_back(core_k);
        else                 m_ovr = 1'b1;
      end
      if (key_wr_en && (m_phase == P_IDLE || m_phase == P_WARM || m_phase == P_RUN)
          && int'(key_addr) < KS)
        m_key[key_addr] = key_data;
      if (start && m_phase != P_RST) begin
        m_phase = P_RST;
      end else begin
        case (m_phase)
          P_RST: begin
            m_q.delete();
            m_ovr   = 1'b0;
            m_phase = P_FEED;
            m_idx   = 0;
          end
          P_FEED: if (m_idx == KS - 1) m_phase = P_WARM; else m_idx++;
          P_WARM: if (core_ready) m_phase = P_RUN;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle compare plus transfer log.
  always @(negedge clk) begin
    int eg;
    eg = pick();
    chk("core_rst", core_rst, (m_phase == P_IDLE || m_phase == P_RST));
    chk("core_key", core_key, (m_phase == P_FEED) ? m_key[m_idx] : 8'h00);
    chk("busy", busy, (m_phase == P_RST || m_phase == P_FEED || m_phase == P_WARM));
    chk("overrun", overrun, m_ovr);
    chk("gnt", gnt, (eg < 0) ? 32'd0 : (32'd1 << eg));
    if (eg >= 0) chk("out_byte", out_byte, m_q[0]);
    if (gnt[0]) begin recv0.push_back(out_byte); $display("xfer req0 byte %02h", out_byte); end
    if (gnt[1]) begin recv1.push_back(out_byte); $display("xfer req1 byte %02h", out_byte); end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_wr(input logic [1:0] a, input logic [7:0] d);
    key_wr_en = 1'b1; key_addr = a; key_data = d;
    tick();
    key_wr_en = 1'b0;
  endtask

  task automatic emit(input logic [7:0] b);
    core_ready = 1'b1; core_k = b;
    tick();
    core_ready = 1'b0;
    tick();
  endtask

  task automatic chk_recv(input int r, input int n, input int base, input int step);
    int sz;
    sz = (r == 0) ? recv0.size() : recv1.size();
    chk($sformatf("recv%0d_len", r), sz, n);
    for (int i = 0; i < n; i++)
      if (i < sz)
        chk($sformatf("recv%0d_%0d", r, i), (r == 0) ? recv0[i] : recv1[i], (base + i * step) & 8'hFF);
  endtask

  task automatic clr_recv();
    recv0.delete();
    recv1.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_wr_en = 1'b0; key_addr = '0; key_data = '0;
    core_ready = 1'b0; core_k = '0; req = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_key", core_key, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_overrun", overrun, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Key load and start; address 3 is out of range and must be ignored.
    key_wr(2'd0, 8'h4B); key_wr(2'd1, 8'h65); key_wr(2'd2, 8'h79); key_wr(2'd3, 8'hEE);
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk); chk("s1_core_rst_on", core_rst, 1);
    tick(); @(negedge clk); chk("s1_key0", core_key, 8'h4B); chk("s1_core_rst_off", core_rst, 0);
    tick(); @(negedge clk); chk("s1_key1", core_key, 8'h65);
    tick(); @(negedge clk); chk("s1_key2", core_key, 8'h79);
    tick(); @(negedge clk); chk("s1_warm_busy", busy, 1); chk("s1_warm_key", core_key, 0);
    tick();

    // Single consumer, byte every other cycle.
    req = 2'b01;
    for (int i = 0; i < 6; i++) emit(8'(i));
    repeat (3) tick();
    chk_recv(0, 6, 0, 1);
    chk("s3_overrun", overrun, 0);
    clr_recv();

    // Two consumers alternate; last served was 0, so requester 1 goes first.
    req = 2'b11;
    for (int i = 0; i < 8; i++) emit(8'(i));
    repeat (3) tick();
    chk_recv(1, 4, 0, 2);
    chk_recv(0, 4, 1, 2);
    clr_recv();

    // Full FIFO with a push and pop on the same edge.
    req = 2'b00;
    for (int i = 0; i < 4; i++) emit(8'(8'h20 + i));
    core_ready = 1'b1; core_k = 8'h24; req = 2'b01;
    tick();
    core_ready = 1'b0;
    repeat (6) tick();
    chk_recv(0, 5, 8'h20, 1);
    chk("s6_overrun", overrun, 0);
    clr_recv();

    // Overflow with no consumer.
    req = 2'b00;
    for (int i = 0; i < 6; i++) emit(8'(8'h30 + i));
    chk("s5_overrun", overrun, 1);
    req = 2'b01;
    repeat (6) tick();
    chk_recv(0, 4, 8'h30, 1);
    clr_recv();

    // Restart mid-RUN with queued bytes; key write during KEYFEED is ignored.
    req = 2'b00;
    emit(8'h40); emit(8'h41);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    key_wr_en = 1'b1; key_addr = 2'd1; key_data = 8'hAA;
    @(negedge clk); chk("s7_key0", core_key, 8'h4B);
    tick(); key_wr_en = 1'b0;
    @(negedge clk); chk("s7_key1_old", core_key, 8'h65);
    tick(); tick();
    req = 2'b01;
    repeat (3) begin
      @(negedge clk); chk("s7_gnt_idle", gnt, 0);
      tick();
    end
    chk("s7_overrun_clr", overrun, 0);
    emit(8'h50);
    repeat (3) tick();
    chk_recv(0, 1, 8'h50, 1);
    clr_recv();

    // Asynchronous reset mid-KEYFEED.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("s8_core_rst", core_rst, 1);
    chk("s8_core_key", core_key, 0);
    chk("s8_busy", busy, 0);
    chk("s8_gnt", gnt, 0);
    chk("s8_overrun", overrun, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    @(negedge clk); chk("s8_key_cleared", core_key, 0);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
